dcache_ctrl: RTL
================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ADDR_W, 13, CPU word-address width.
- DATA_W, 16, CPU word width.
- LINE_WORDS, 4, words per line; power of 2, at least 2.
- SETS, 64, direct-mapped set count; power of 2.
REQ-002 Derived widths: OFF_W=log2(LINE_WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W-OFF_W-IDX_W (SHALL be at least 1), LINE_W=DATA_W*LINE_WORDS.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- cpu_addr, in, ADDR_W, word address.
- cpu_re, in, 1, read request.
- cpu_we, in, 1, write request.
- cpu_wdata, in, DATA_W, write word.
- cpu_rdata, out, DATA_W, read word.
- cpu_rdy, out, 1, access complete this cycle.
- mem_addr, out, ADDR_W-OFF_W, line address.
- mem_re, out, 1, line read request.
- mem_we, out, 1, line write request.
- mem_wline, out, LINE_W, evicted line.
- mem_rline, in, LINE_W, fill line.
- mem_rdy, in, 1, memory operation done.
- snp_valid, in, 1, other-processor lookup.
- snp_addr, in, ADDR_W, lookup word address.
- snp_hit, out, 1, lookup hit (registered).
- snp_data, out, DATA_W, lookup word (registered).
- miss, out, 1, one-cycle pulse on miss detection.
- hit_cnt, out, 16, hit counter.
- miss_cnt, out, 16, miss counter.

Function
REQ-004 Address split SHALL be tag=cpu_addr[ADDR_W-1:OFF_W+IDX_W], index=next IDX_W bits, offset=low OFF_W bits; word w of a line SHALL occupy bits [DATA_W*(w+1)-1:DATA_W*w].
REQ-005 Storage per set SHALL be a valid bit, a dirty bit, a TAG_W tag and LINE_W data; all writes SHALL occur on the rising edge of clk.
REQ-006 Requests with cpu_re and cpu_we both high SHALL be treated as writes.
REQ-007 The FSM SHALL have three states: IDLE, EVICT and FILL.
REQ-008 IDLE hit (valid and tag match): cpu_rdy=1 the same cycle, with zero wait states.
- Read: cpu_rdata = addressed word, combinational.
- Write: the addressed word SHALL be updated and dirty set at the next edge.
REQ-009 IDLE with no request: cpu_rdy=1; cpu_rdata SHALL still reflect the addressed word.
REQ-010 IDLE miss: cpu_rdy=0 and miss=1 for one cycle.
- The controller SHALL latch address, wdata and the write flag.
- Go to EVICT if the victim is valid and dirty; otherwise go to FILL.
REQ-011 EVICT: mem_we=1, mem_addr={victim tag, index}, mem_wline=victim line, all held stable until mem_rdy; then go to FILL.
REQ-012 FILL: mem_re=1 and mem_addr=latched line address, held until mem_rdy.
REQ-013 On the mem_rdy cycle in FILL:
- Write mem_rline into the set, merged with latched wdata at the latched offset if the access is a write.
- Set valid; set dirty to the write flag; write the tag.
- Drive cpu_rdy=1 and cpu_rdata = the merged word in that same cycle, then return to IDLE.
REQ-014 mem_re and mem_we SHALL never be high together; both SHALL be 0 in IDLE.
REQ-015 CPU inputs changing during EVICT or FILL SHALL NOT affect the transfer, which completes using the latched values.
REQ-016 Snoop: when snp_valid is high at an edge, snp_hit and snp_data SHALL be updated at that edge from array contents before that edge's write; when snp_valid is low, both SHALL hold.
- Snoops SHALL never change valid, dirty, tag or data, nor stall the CPU.
REQ-017 Clean-miss latency: cpu_rdy SHALL be asserted on the cycle mem_rdy is first seen in FILL. Dirty-miss latency: the EVICT handshake plus the FILL handshake.

Reset
REQ-018 On rst_n low, the controller SHALL asynchronously go to IDLE and clear all valid and dirty bits, miss, mem_re, mem_we, snp_hit, snp_data, hit_cnt and miss_cnt; the data and tag arrays are not reset.
REQ-019 Reset mid-EVICT or mid-FILL SHALL abandon the transfer; mem_re and mem_we SHALL fall immediately.

Configuration
REQ-020 With macro DCACHE_CTRL_STATS_EN defined, hit_cnt SHALL increment on each IDLE hit with a request, and miss_cnt SHALL increment on each miss pulse.
- Both counters SHALL saturate at 16'hFFFF.
- A completed fill SHALL NOT count as a hit.
REQ-021 Without DCACHE_CTRL_STATS_EN, hit_cnt and miss_cnt SHALL be constant 0 and no counter flops SHALL be inferred.

Verification
REQ-022 After reset, read 13'h0040 with mem_rdy delayed 3 cycles -> miss pulse; mem_re with mem_addr 11'h010 for 3 cycles; cpu_rdy on the mem_rdy cycle with the word 0 of the fill; an immediate re-read hits with cpu_rdy in the same cycle.
REQ-023 Write 16'hBEEF to 13'h0041 (line resident) -> no mem activity; dirty set; read of 13'h0041 returns 16'hBEEF.
REQ-024 Read 13'h0841 (same index, new tag) with a dirty victim -> EVICT: mem_we, mem_addr 11'h010, mem_wline with 16'hBEEF in word 1; then FILL at mem_addr 11'h210; mem_re and mem_we never overlap.
REQ-025 Snoop 13'h0841 while the CPU is in FILL for that line -> snp_hit=0 on the edge the fill writes; snoop 13'h0841 on the next edge -> snp_hit=1 with the filled word 1.
REQ-026 Drop rst_n during FILL -> mem_re low immediately; after release, the previous line reads as a miss.
REQ-027 With DCACHE_CTRL_STATS_EN defined: 3 misses and 5 hits -> miss_cnt=3, hit_cnt=5; counters preloaded to 16'hFFFF stay at 16'hFFFF on further events; without the macro both counters read 0.

Source files
------------

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped, write-back, write-allocate data cache
//                controller. Hits complete with zero wait states. Misses
//                evict a dirty victim and then fill the line. A registered
//                snoop port lets another processor look into the cache
//                without stalling the CPU.
//                Optional hit/miss statistics: define DCACHE_CTRL_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [ADDR_W-1:0]                          cpu_addr,
    input  logic                                       cpu_re,
    input  logic                                       cpu_we,
    input  logic [DATA_W-1:0]                          cpu_wdata,
    output logic [DATA_W-1:0]                          cpu_rdata,
    output logic                                       cpu_rdy,
    output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]       mem_addr,
    output logic                                       mem_re,
    output logic                                       mem_we,
    output logic [DATA_W*LINE_WORDS-1:0]               mem_wline,
    input  logic [DATA_W*LINE_WORDS-1:0]               mem_rline,
    input  logic                                       mem_rdy,
    input  logic                                       snp_valid,
    input  logic [ADDR_W-1:0]                          snp_addr,
    output logic                                       snp_hit,
    output logic [DATA_W-1:0]                          snp_data,
    output logic                                       miss,
    output logic [15:0]                                hit_cnt,
    output logic [15:0]                                miss_cnt
);

    localparam int c_OFF_W  = $clog2(LINE_WORDS);
    localparam int c_IDX_W  = $clog2(SETS);
    localparam int c_TAG_W  = ADDR_W - c_OFF_W - c_IDX_W;
    localparam int c_LINE_W = DATA_W * LINE_WORDS;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_EVICT = 2'd1;
    localparam logic [1:0] c_FILL  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next;

    logic [SETS-1:0]     r_valid;
    logic [SETS-1:0]     r_dirty;
    logic [c_TAG_W-1:0]  r_tag_arr  [SETS];
    logic [c_LINE_W-1:0] r_data_arr [SETS];

    // Request captured at miss time; the transfer runs from these only
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wr;

    logic [c_TAG_W-1:0]  w_tag,  r_tag,  w_stag;
    logic [c_IDX_W-1:0]  w_idx,  r_idx,  w_sidx;
    logic [c_OFF_W-1:0]  w_off,  r_off,  w_soff;
    logic [c_LINE_W-1:0] w_line;
    logic [c_LINE_W-1:0] w_fill_line;
    logic                w_hit, w_req, w_idle, w_miss, w_hit_req, w_fill_done;

    assign w_tag  = cpu_addr[ADDR_W-1 -: c_TAG_W];
    assign w_idx  = cpu_addr[c_OFF_W +: c_IDX_W];
    assign w_off  = cpu_addr[c_OFF_W-1:0];
    assign r_tag  = r_addr[ADDR_W-1 -: c_TAG_W];
    assign r_idx  = r_addr[c_OFF_W +: c_IDX_W];
    assign r_off  = r_addr[c_OFF_W-1:0];
    assign w_stag = snp_addr[ADDR_W-1 -: c_TAG_W];
    assign w_sidx = snp_addr[c_OFF_W +: c_IDX_W];
    assign w_soff = snp_addr[c_OFF_W-1:0];

    assign w_line      = r_data_arr[w_idx];
    assign w_hit       = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
    assign w_req       = cpu_re | cpu_we;
    assign w_idle      = (r_state == c_IDLE);
    assign w_miss      = w_idle && w_req && !w_hit;
    assign w_hit_req   = w_idle && w_req && w_hit;
    assign w_fill_done = (r_state == c_FILL) && mem_rdy;

    // Miss pulse is forced low while reset is asserted
    assign miss = w_miss & rst_n;

    // Fill line with the pending write word merged in at the latched offset
    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_merge
        assign w_fill_line[g*DATA_W +: DATA_W] =
            (r_wr && (r_off == c_OFF_W'(g))) ? r_wdata : mem_rline[g*DATA_W +: DATA_W];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode and CPU/memory handshake outputs
    always_comb begin
        w_next    = r_state;
        cpu_rdy   = 1'b0;
        cpu_rdata = w_line[w_off*DATA_W +: DATA_W];
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_addr[ADDR_W-1:c_OFF_W];
        mem_wline = r_data_arr[r_idx];
        case (r_state)
            c_IDLE: begin
                cpu_rdy = !w_miss;
                if (w_miss)
                    w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? c_EVICT : c_FILL;
            end
            c_EVICT: begin
                mem_we   = 1'b1;
                mem_addr = {r_tag_arr[r_idx], r_idx};
                if (mem_rdy) w_next = c_FILL;
            end
            c_FILL: begin
                mem_re = 1'b1;
                if (mem_rdy) begin
                    cpu_rdy   = 1'b1;
                    cpu_rdata = w_fill_line[r_off*DATA_W +: DATA_W];
                    w_next    = c_IDLE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Valid/dirty flags: cleared by reset, set by fills and write hits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill_done) begin
            r_valid[r_idx] <= 1'b1;
            r_dirty[r_idx] <= r_wr;
        end else if (w_hit_req && cpu_we) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    // Tag/data arrays and the latched miss request (not reset)
    always_ff @(posedge clk) begin
        if (w_miss) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_wr    <= cpu_we;
        end
        if (w_fill_done) begin
            r_data_arr[r_idx] <= w_fill_line;
            r_tag_arr[r_idx]  <= r_tag;
        end else if (w_hit_req && cpu_we) begin
            r_data_arr[w_idx][w_off*DATA_W +: DATA_W] <= cpu_wdata;
        end
    end

    // Snoop lookup sees array contents from before this edge's update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snp_hit  <= 1'b0;
            snp_data <= '0;
        end else if (snp_valid) begin
            snp_hit  <= r_valid[w_sidx] && (r_tag_arr[w_sidx] == w_stag);
            snp_data <= r_data_arr[w_sidx][w_soff*DATA_W +: DATA_W];
        end
    end

`ifdef DCACHE_CTRL_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // Saturating hit/miss statistics; fill completions are not hits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_req && (r_hit_cnt != 16'hFFFF))
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (w_miss && (r_miss_cnt != 16'hFFFF))
                r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
`default_nettype wire
